// File: rtl/ad9250_spi_slave.sv
// rtl/ad9250_spi_slave.sv - 3-wire AD9250-style SPI responder with a small register file.
// Optional read-only chip ID at address 13'h001 when SPI_SLAVE_CHIP_ID_EN is defined.
module ad9250_spi_slave #(
   parameter int         REG_NUM     = 16,
   parameter int         SYNC_STAGES = 2,
   parameter logic [7:0] CHIP_ID     = 8'hAD
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ss,
   input  logic        sck,
   input  logic        mosi,
   output logic        miso,
   output logic        miso_oe,
   output logic        wr_stb,
   output logic [12:0] wr_addr,
   output logic [7:0]  wr_data,
   output logic        rd_stb,
   output logic        frame_err
);

   localparam int          AW      = (REG_NUM > 1) ? $clog2(REG_NUM) : 1;
   localparam logic [13:0] REG_LIM = 14'(REG_NUM);

   typedef enum logic [2:0] {IDLE, INSTR, DATA_WR, DATA_RD, DONE} state_t;

   logic [SYNC_STAGES-1:0] ss_sync, sck_sync, mosi_sync;
   logic                   ss_q, sck_q;
   logic                   ss_rise, ss_fall, sck_rise, mosi_bit;

   state_t      state;
   logic [3:0]  cnt;
   logic [15:0] instr;
   logic [6:0]  dsr;
   logic [6:0]  rsr;
   logic [7:0]  regs [REG_NUM];

   logic [15:0] instr_n;
   logic [7:0]  data_n;
   logic [7:0]  rd_byte;
   logic        wr_ok;

   // Edge pulses are registered so mosi_bit and the pulses line up in the same cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ss_sync   <= '1;
         sck_sync  <= '1;
         mosi_sync <= '0;
         ss_q      <= 1'b1;
         sck_q     <= 1'b1;
         ss_rise   <= 1'b0;
         ss_fall   <= 1'b0;
         sck_rise  <= 1'b0;
         mosi_bit  <= 1'b0;
      end else begin
         ss_sync   <= {ss_sync[SYNC_STAGES-2:0], ss};
         sck_sync  <= {sck_sync[SYNC_STAGES-2:0], sck};
         mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
         ss_q      <= ss_sync[SYNC_STAGES-1];
         sck_q     <= sck_sync[SYNC_STAGES-1];
         ss_rise   <= ss_sync[SYNC_STAGES-1] & ~ss_q;
         ss_fall   <= ~ss_sync[SYNC_STAGES-1] & ss_q;
         sck_rise  <= sck_sync[SYNC_STAGES-1] & ~sck_q & ~ss_sync[SYNC_STAGES-1];
         mosi_bit  <= mosi_sync[SYNC_STAGES-1];
      end
   end

   assign instr_n = {mosi_bit, instr[15:1]};
   assign data_n  = {mosi_bit, dsr};

   always_comb begin
      rd_byte = 8'h00;
      if ({1'b0, instr_n[12:0]} < REG_LIM)
         rd_byte = regs[instr_n[AW-1:0]];
`ifdef SPI_SLAVE_CHIP_ID_EN
      if (instr_n[12:0] == 13'h001)
         rd_byte = CHIP_ID;
`endif
   end

   always_comb begin
      wr_ok = ({1'b0, instr[12:0]} < REG_LIM);
`ifdef SPI_SLAVE_CHIP_ID_EN
      if (instr[12:0] == 13'h001)
         wr_ok = 1'b0;
`endif
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         instr     <= '0;
         dsr       <= '0;
         rsr       <= '0;
         miso      <= 1'b0;
         miso_oe   <= 1'b0;
         wr_stb    <= 1'b0;
         rd_stb    <= 1'b0;
         frame_err <= 1'b0;
         wr_addr   <= '0;
         wr_data   <= '0;
         for (int i = 0; i < REG_NUM; i++)
            regs[i] <= 8'h00;
      end else begin
         wr_stb    <= 1'b0;
         rd_stb    <= 1'b0;
         frame_err <= 1'b0;
         case (state)
            IDLE: begin
               if (ss_fall) begin
                  state <= INSTR;
                  cnt   <= '0;
               end
            end
            INSTR: begin
               if (ss_rise) begin
                  frame_err <= 1'b1;
                  state     <= IDLE;
               end else if (sck_rise) begin
                  instr <= instr_n;
                  cnt   <= cnt + 4'd1;
                  if (cnt == 4'd15) begin
                     cnt <= '0;
                     if (instr_n[15]) begin
                        state   <= DATA_RD;
                        rsr     <= rd_byte[7:1];
                        miso    <= rd_byte[0];
                        miso_oe <= 1'b1;
                        rd_stb  <= 1'b1;
                     end else begin
                        state <= DATA_WR;
                     end
                  end
               end
            end
            DATA_WR: begin
               if (ss_rise) begin
                  frame_err <= 1'b1;
                  state     <= IDLE;
               end else if (sck_rise) begin
                  dsr <= data_n[7:1];
                  cnt <= cnt + 4'd1;
                  if (cnt == 4'd7) begin
                     state <= DONE;
                     if (wr_ok) begin
                        regs[instr[AW-1:0]] <= data_n;
                        wr_stb              <= 1'b1;
                        wr_addr             <= instr[12:0];
                        wr_data             <= data_n;
                     end
                  end
               end
            end
            DATA_RD: begin
               if (ss_rise) begin
                  frame_err <= 1'b1;
                  state     <= IDLE;
                  miso      <= 1'b0;
                  miso_oe   <= 1'b0;
               end else if (sck_rise) begin
                  cnt <= cnt + 4'd1;
                  // The 8th edge leaves bit 7 on miso until ss rises.
                  if (cnt == 4'd7) begin
                     state <= DONE;
                  end else begin
                     miso <= rsr[0];
                     rsr  <= {1'b0, rsr[6:1]};
                  end
               end
            end
            DONE: begin
               if (ss_rise) begin
                  state   <= IDLE;
                  miso    <= 1'b0;
                  miso_oe <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ad9250_spi_slave.sv
// tb/tb_ad9250_spi_slave.sv - randomized frame-level bench for ad9250_spi_slave.
// Expected results come from a register-array model of the frame rules.
module tb_ad9250_spi_slave;

   localparam int REG_NUM = 16;
   localparam int H       = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        ss = 1'b1, sck = 1'b1, mosi = 1'b0;
   logic        miso, miso_oe, wr_stb, rd_stb, frame_err;
   logic [12:0] wr_addr;
   logic [7:0]  wr_data;

   int          n_checks = 0;
   int          n_pass = 0;
   int          wr_seen = 0, rd_seen = 0, err_seen = 0;
   logic [12:0] last_wa = '0;
   logic [7:0]  last_wd = '0;
   logic [7:0]  model [REG_NUM];

   ad9250_spi_slave #(.REG_NUM(REG_NUM), .SYNC_STAGES(2), .CHIP_ID(8'hAD)) dut (
      .clk(clk), .rst(rst), .ss(ss), .sck(sck), .mosi(mosi),
      .miso(miso), .miso_oe(miso_oe), .wr_stb(wr_stb), .wr_addr(wr_addr),
      .wr_data(wr_data), .rd_stb(rd_stb), .frame_err(frame_err)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (!rst) begin
         if (wr_stb) begin
            wr_seen++;
            last_wa = wr_addr;
            last_wd = wr_data;
         end
         if (rd_stb) rd_seen++;
         if (frame_err) err_seen++;
      end
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached, got running expected finished");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   function automatic logic [7:0] exp_read(input logic [12:0] a);
      if (a >= REG_NUM) return 8'h00;
`ifdef SPI_SLAVE_CHIP_ID_EN
      if (a == 13'h001) return 8'hAD;
`endif
      return model[a[3:0]];
   endfunction

   function automatic bit writable(input logic [12:0] a);
      if (a >= REG_NUM) return 1'b0;
`ifdef SPI_SLAVE_CHIP_ID_EN
      if (a == 13'h001) return 1'b0;
`endif
      return 1'b1;
   endfunction

   // One frame of nbits sck cycles; nbits < 24 aborts, nbits > 24 over-runs.
   task automatic frame(input logic rw, input logic [12:0] addr, input logic [7:0] data,
                        input int nbits, input string tag);
      logic [23:0] f;
      logic [7:0]  exp, got, mask;
      int          w0, r0, e0, nb;
      bit          oe_ok, over_ok, exp_wr;
      f = {data, rw, 2'($urandom), addr};
      exp = exp_read(addr);
      got = '0;
      oe_ok = 1'b1;
      over_ok = 1'b1;
      w0 = wr_seen; r0 = rd_seen; e0 = err_seen;
      ss = 1'b0;
      wait_clk(H);
      for (int i = 0; i < nbits; i++) begin
         sck = 1'b0;
         mosi = (i < 24) ? f[i] : 1'($urandom);
         wait_clk(H);
         if (i >= 16) begin
            @(negedge clk);
            if (miso_oe !== rw) oe_ok = 1'b0;
            if (rw && i < 24) got[i-16] = miso;
            if (rw && i >= 24 && miso !== exp[7]) over_ok = 1'b0;
         end
         sck = 1'b1;
         wait_clk(H);
      end
      wait_clk(2);
      ss = 1'b1;
      wait_clk(12);
      exp_wr = !rw && nbits >= 24 && writable(addr);
      check({tag, "/wr_cnt"}, wr_seen - w0, exp_wr ? 1 : 0);
      if (exp_wr) begin
         check({tag, "/wr_addr"}, last_wa, addr);
         check({tag, "/wr_data"}, last_wd, data);
         model[addr[3:0]] = data;
      end
      check({tag, "/rd_cnt"}, rd_seen - r0, (rw && nbits >= 16) ? 1 : 0);
      check({tag, "/err_cnt"}, err_seen - e0, (nbits < 24) ? 1 : 0);
      if (nbits > 16) check({tag, "/oe_data"}, oe_ok, 1);
      if (rw && nbits > 16) begin
         nb = (nbits >= 24) ? 8 : nbits - 16;
         mask = 8'((1 << nb) - 1);
         check({tag, "/rd_data"}, got & mask, exp & mask);
      end
      if (rw && nbits > 24) check({tag, "/over_miso"}, over_ok, 1);
      check({tag, "/oe_idle"}, miso_oe, 0);
   endtask

   initial begin
      logic        rw;
      logic [12:0] a;
      logic [7:0]  d;
      int          r, nb;
      logic [23:0] f;
      for (int i = 0; i < REG_NUM; i++) model[i] = 8'h00;

      wait_clk(3);
      check("reset_outs", {miso, miso_oe, wr_stb, rd_stb, frame_err, wr_addr, wr_data}, 0);
      rst = 1'b0;
      wait_clk(10);

      frame(1'b0, 13'h004, 8'h5A, 24, "wr4");
      frame(1'b1, 13'h004, 8'h00, 24, "rd4");
      frame(1'b0, 13'h100, 8'h77, 24, "wr_oor");
      frame(1'b1, 13'h100, 8'h00, 24, "rd_oor");
      frame(1'b0, 13'h002, 8'h11, 24, "wr2");
      frame(1'b0, 13'h002, 8'hEE, 20, "abort2");
      frame(1'b1, 13'h002, 8'h00, 24, "rd2");
      frame(1'b0, 13'h003, 8'h3C, 32, "over3");
      frame(1'b1, 13'h003, 8'h00, 24, "rd3");
      frame(1'b0, 13'h001, 8'hFF, 24, "wr1");
      frame(1'b1, 13'h001, 8'h00, 24, "rd1");

      // Reset in the middle of a read, at bit 19.
      f = {8'h00, 1'b1, 2'b00, 13'h004};
      ss = 1'b0;
      wait_clk(H);
      for (int i = 0; i < 20; i++) begin
         sck = 1'b0;
         mosi = f[i];
         wait_clk(H);
         if (i == 19) begin
            check("mid_read_oe_before", miso_oe, 1);
            rst = 1'b1;
            #1;
            check("mid_read_oe_reset", miso_oe, 0);
            check("mid_read_outs", {miso, wr_stb, rd_stb, frame_err, wr_addr, wr_data}, 0);
         end else begin
            sck = 1'b1;
            wait_clk(H);
         end
      end
      ss = 1'b1;
      sck = 1'b1;
      wait_clk(5);
      rst = 1'b0;
      wait_clk(10);
      for (int i = 0; i < REG_NUM; i++) model[i] = 8'h00;
      for (int i = 0; i < REG_NUM; i++) frame(1'b1, 13'(i), 8'h00, 24, "rd_after_rst");

      for (int k = 0; k < 40; k++) begin
         rw = 1'($urandom_range(0, 1));
         a = ($urandom_range(0, 3) == 0) ? 13'($urandom) : 13'($urandom_range(0, REG_NUM - 1));
         d = 8'($urandom);
         r = $urandom_range(0, 9);
         nb = (r < 6) ? 24 : (r < 8) ? $urandom_range(25, 32) : $urandom_range(0, 23);
         frame(rw, a, d, nb, "rand");
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/ad9250_spi_slave.md
# ad9250_spi_slave

Synthesizable responder for the 3-wire AD9250-style SPI port driven by `spi_master`. It decodes 24-bit frames (16-bit instruction plus one data byte), maintains a small on-chip register file, answers reads on `miso`, and reports accepted writes to the surrounding logic. It is used as a loop-back target for master bring-up and as the control-port front end of an emulated ADC.

## Interface
- `REG_NUM`, 16: register-file depth. Addresses `0..REG_NUM-1` are implemented.
- `SYNC_STAGES`, 2: synchronizer depth on `ss`, `sck` and `mosi`. Legal values are 2 or 3.
- `CHIP_ID`, 8'hAD: value returned at address 13'h001 when `SPI_SLAVE_CHIP_ID_EN` is defined.

Ports:
- `clk` input, 1 bit: system clock. Every flop in the block uses this one clock.
- `rst` input, 1 bit: reset, asynchronous and active-high.
- `ss` input, 1 bit: chip select, active-low.
- `sck` input, 1 bit: SPI clock, idles high.
- `mosi` input, 1 bit: serial data from the master.
- `miso` output, 1 bit: serial read data.
- `miso_oe` output, 1 bit: high while the slave drives `miso`.
- `wr_stb` output, 1 bit: one-cycle pulse when a write is accepted.
- `wr_addr` output, 13 bits: address of the last accepted write.
- `wr_data` output, 8 bits: data of the last accepted write.
- `rd_stb` output, 1 bit: one-cycle pulse when read data is loaded for shifting.
- `frame_err` output, 1 bit: one-cycle pulse when a frame is aborted.

## Operation
- Input handling:
  - `ss`, `sck` and `mosi` pass through `SYNC_STAGES` flops before any logic uses them.
  - Edges are detected on the synchronized signals.
- Frame word `F[23:0]`, sent bit 0 first, LSB-first on the wire:
  - `F[12:0]` is the address.
  - `F[14:13]` is W1W0. It is captured and ignored; the frame length is always one byte.
  - `F[15]` is R/W, with 1 meaning read.
  - `F[23:16]` is the data byte.
- `mosi` is sampled on each detected `sck` rising edge while `ss` is low.
- State machine transitions:
  - IDLE → INSTR on a detected `ss` falling edge. The bit counter is cleared.
  - INSTR → DATA_RD after the 16th rising edge when R/W=1.
    - The register is loaded into the shift register and `rd_stb` pulses.
    - `miso` = bit 0 and `miso_oe`=1 in the same cycle.
  - INSTR → DATA_WR after the 16th rising edge when R/W=0.
  - DATA_WR → DONE after the 24th rising edge.
    - If the address is below `REG_NUM`, the register is written and `wr_stb` pulses with `wr_addr`/`wr_data`.
    - Otherwise the write is dropped and `wr_stb` stays low.
  - DATA_RD shifting: each detected rising edge shifts `miso` to the next bit. After 8 edges the state moves to DONE. `miso` holds bit 7 until `ss` rises.
  - DONE → IDLE on a detected `ss` rising edge. `miso_oe` drops in the same cycle.
- Reads:
  - An address at or above `REG_NUM` returns 8'h00 and still pulses `rd_stb`.
- Abort and error cases:
  - `ss` rises in INSTR, DATA_WR or DATA_RD: `frame_err` pulses, no write occurs, and the state returns to IDLE.
  - Rising edges in DONE are ignored; a frame longer than 24 bits does not wrap.
  - `ss` falls while not in IDLE: this is impossible without a rise first. A rise and a fall within one cycle after synchronization is treated as abort followed by a new frame.

## Timing
- Reset values:
  - `miso`=0, `miso_oe`=0, `wr_stb`=0, `rd_stb`=0, `frame_err`=0.
  - `wr_addr`=0, `wr_data`=0.
  - All registers are 0 and the state is IDLE.
- `sck` high and low phases must each be at least `SYNC_STAGES`+1 `clk` periods. `CLK_DIV`=6 on the same `clk` meets this.
- Latencies:
  - Pin edge to internal edge pulse: `SYNC_STAGES`+1 cycles.
  - `miso` changes one cycle after the internal rising-edge pulse. This is after the master's sample point and at least `SYNC_STAGES`+1 cycles before the next rising edge.
  - `wr_stb` is asserted `SYNC_STAGES`+2 cycles after the 24th pin rising edge.
- Reset mid-frame: outputs return to their reset values immediately and the register file clears.

## Configuration
- `SPI_SLAVE_CHIP_ID_EN`:
  - Defined: address 13'h001 is read-only and returns `CHIP_ID`. A write to 13'h001 is dropped, and `wr_stb` stays low.
  - Undefined: 13'h001 is an ordinary read/write register.

## Test plan
- Write then read: write frame addr 13'h004, data 8'h5A; `wr_stb` pulses once with `wr_addr`=13'h004, `wr_data`=8'h5A. A following read of 13'h004 shifts out 8'h5A LSB-first, `rd_stb` pulses, and `miso_oe` is high for exactly the data phase.
- Out-of-range access: write to addr 13'h100 with `REG_NUM`=16 gives no `wr_stb`. A read of 13'h100 returns 8'h00.
- Abort: `ss` rises after 20 bits of a write to 13'h002. `frame_err` pulses, `wr_stb` stays low, and a read of 13'h002 returns the prior value.
- Over-length frame: a 32-clock frame writing 8'h3C to 13'h003 gives exactly one `wr_stb` with data 8'h3C, and the extra edges are ignored.
- Reset mid-read: assert `rst` at bit 19 of a read. `miso_oe`=0 immediately, and all registers read 8'h00 afterwards.
- Chip ID, with macro defined: write 8'hFF to 13'h001 gives no `wr_stb`. A read of 13'h001 returns 8'hAD.
